// File: rtl/cnn_pkg.sv
// Shared types and size helpers for the pooling feature-map buffer.
// Pool FSM state encoding plus H/W-derived output geometry functions.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    CMP,
    WR,
    DONE
  } pool_state_t;

  function automatic int pool_oh(input int h);
    return h / 2;
  endfunction

  function automatic int pool_ow(input int w);
    return w / 2;
  endfunction

  function automatic int pool_out_n(input int h, input int w);
    return (h / 2) * (w / 2);
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// Inferred RAM: one write port, two registered read ports.
// Ports: we/waddr/wdata write; re1/raddr1, re2/raddr2 reads -> rdata1/rdata2.
module fmap_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 784,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd1_q, rd1_d;
  logic [DW-1:0] rd2_q, rd2_d;
  logic          w_ok, r1_ok, r2_ok;

  // Range checks only exist when the address space is
  // larger than the array.
  if (DEPTH < (2 ** AW)) begin : g_rng
    assign w_ok  = waddr  < AW'(DEPTH);
    assign r1_ok = raddr1 < AW'(DEPTH);
    assign r2_ok = raddr2 < AW'(DEPTH);
  end else begin : g_full
    assign w_ok  = 1'b1;
    assign r1_ok = 1'b1;
    assign r2_ok = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we && w_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (re1) begin
      rd1_d = r1_ok ? mem[raddr1] : '0;
    end
    if (re2) begin
      rd2_d = r2_ok ? mem[raddr2] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign rdata1 = rd1_q;
  assign rdata2 = rd2_q;

endmodule

// File: rtl/fmap_pool_buf.sv
// Feature-map buffer with host R/W and in-place 2x2/s2 max-pool (+ReLU).
// Ports: we/waddr/wdata, load/raddr1/raddr2 -> dout1/dout2, pool_start/relu_en -> pool_busy/pool_done.
module fmap_pool_buf
  import cnn_pkg::*;
#(
  parameter int DW = 8,
  parameter int H  = 28,
  parameter int W  = 28,
  parameter int AW = $clog2(H * W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          load,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] dout1,
  output logic [DW-1:0] dout2,
  input  logic          pool_start,
  input  logic          relu_en,
  output logic          pool_busy,
  output logic          pool_done
);

  localparam int OH    = pool_oh(H);
  localparam int OW    = pool_ow(W);
  localparam int OUT_N = pool_out_n(H, W);

  pool_state_t state_q, state_d;

  logic [AW-1:0]        r_q, r_d;
  logic [AW-1:0]        c_q, c_d;
  logic signed [DW-1:0] max_q, max_d;
  logic                 relu_q, relu_d;
  logic [DW-1:0]        hold_q, hold_d;
  logic                 host_q, host_d;

  logic                 busy;
  logic                 host_we;
  logic                 host_ld;
  logic                 eng_rd;
  logic                 eng_wr;
  logic [AW-1:0]        base;
  logic [AW-1:0]        eng_raddr;
  logic [AW-1:0]        out_addr;
  logic [DW-1:0]        wr_val;
  logic signed [DW-1:0] sample;

  logic                 ram_we;
  logic [AW-1:0]        ram_waddr;
  logic [DW-1:0]        ram_wdata;
  logic                 ram_re1;
  logic [AW-1:0]        ram_raddr1;
  logic [DW-1:0]        rd1;
  logic [DW-1:0]        rd2;

  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign host_we = we && !busy;
  assign host_ld = load && !busy;
  assign eng_wr  = (state_q == WR);

  assign base     = AW'(32'(r_q) * 2 * W + 32'(c_q) * 2);
  assign out_addr = AW'(32'(r_q) * OW + 32'(c_q));
  assign sample   = $signed(rd1);
  assign wr_val   = (relu_q && max_q[DW-1]) ? '0 : max_q;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    max_d     = max_q;
    relu_d    = relu_q;
    eng_rd    = 1'b0;
    eng_raddr = base;
    case (state_q)
      IDLE: begin
        if (pool_start) begin
          relu_d  = relu_en;
          r_d     = '0;
          c_d     = '0;
          state_d = (OUT_N == 0) ? DONE : RD0;
        end
      end
      RD0: begin
        eng_rd  = 1'b1;
        state_d = RD1;
      end
      RD1: begin
        eng_rd    = 1'b1;
        eng_raddr = base + AW'(1);
        max_d     = sample;
        state_d   = RD2;
      end
      RD2: begin
        eng_rd    = 1'b1;
        eng_raddr = base + AW'(W);
        if (sample > max_q) max_d = sample;
        state_d   = RD3;
      end
      RD3: begin
        eng_rd    = 1'b1;
        eng_raddr = base + AW'(W + 1);
        if (sample > max_q) max_d = sample;
        state_d   = CMP;
      end
      CMP: begin
        if (sample > max_q) max_d = sample;
        state_d = WR;
      end
      WR: begin
        if (c_q == AW'(OW - 1)) begin
          c_d = '0;
          if (r_q == AW'(OH - 1)) begin
            r_d     = '0;
            state_d = DONE;
          end else begin
            r_d     = r_q + AW'(1);
            state_d = RD0;
          end
        end else begin
          c_d     = c_q + AW'(1);
          state_d = RD0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port 1 of the RAM is shared with the engine. While it
  // is borrowed, dout1 comes from hold_q, which snapshots
  // the last host result on the first engine read.
  always_comb begin
    host_d = host_q;
    hold_d = hold_q;
    if (host_ld) begin
      host_d = 1'b1;
    end else if (eng_rd) begin
      host_d = 1'b0;
      if (host_q) hold_d = rd1;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = waddr;
    ram_wdata = wdata;
    unique case (1'b1)
      eng_wr: begin
        ram_we    = 1'b1;
        ram_waddr = out_addr;
        ram_wdata = wr_val;
      end
      host_we: begin
        ram_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_re1    = 1'b0;
    ram_raddr1 = raddr1;
    unique case (1'b1)
      eng_rd: begin
        ram_re1    = 1'b1;
        ram_raddr1 = eng_raddr;
      end
      host_ld: begin
        ram_re1 = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      max_q   <= '0;
      relu_q  <= 1'b0;
      hold_q  <= '0;
      host_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      max_q   <= max_d;
      relu_q  <= relu_d;
      hold_q  <= hold_d;
      host_q  <= host_d;
    end
  end

  fmap_ram #(
    .DW   (DW),
    .DEPTH(H * W),
    .AW   (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re1   (ram_re1),
    .raddr1(ram_raddr1),
    .re2   (host_ld),
    .raddr2(raddr2),
    .rdata1(rd1),
    .rdata2(rd2)
  );

  assign dout1     = host_q ? rd1 : hold_q;
  assign dout2     = rd2;
  assign pool_busy = busy;
  assign pool_done = (state_q == DONE);

endmodule
